// File: rtl/enc_pkg.sv
// Shared constants and helpers for the priority-encoder family.
// Mode encodings select which set request bit wins.
package enc_pkg;

   localparam int ENC_LOW_FIRST  = 0;
   localparam int ENC_HIGH_FIRST = 1;
   localparam int ENC_RR         = 2;

   // Index width that never collapses to zero bits for tiny vectors.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/prio_find_first.sv
// Combinational find-first: reports the first set bit of vec_i scanning
// upward (DIR=0, lowest index) or downward (DIR=1, highest index).
module prio_find_first
   import enc_pkg::*;
#(
   parameter int N   = 8,
   parameter int DIR = 0,
   localparam int W  = clog2_min1(N)
) (
   input  logic [N-1:0] vec_i,
   output logic [W-1:0] idx_o,
   output logic [N-1:0] onehot_o,
   output logic         found_o
);

   // Walk away from the winning end so the last hit written is the winner.
   always_comb begin
      idx_o    = '0;
      onehot_o = '0;
      found_o  = |vec_i;
      for (int i = 0; i < N; i++) begin
         int j;
         j = (DIR == 0) ? (N - 1 - i) : i;
         if (vec_i[j]) begin
            idx_o       = W'(j);
            onehot_o    = '0;
            onehot_o[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prio_encoder_rr.sv
// N-to-log2(N) priority encoder with fixed-low, fixed-high or round-robin
// arbitration, a one-deep registered output stage and valid/ready handshakes.
module prio_encoder_rr
   import enc_pkg::*;
#(
   parameter int N    = 8,
   parameter int MODE = 0,
   localparam int W   = clog2_min1(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] d,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] y,
   output logic [N-1:0] onehot,
   output logic         any,
   output logic         multi,
   output logic         out_valid,
   input  logic         out_ready
);

   if (MODE > ENC_RR || N < 2 || N > 64) begin : gIllegal
      $error("prio_encoder_rr: illegal parameters N=%0d MODE=%0d", N, MODE);
   end

   logic [W-1:0] ptr_q, ptr_d;
   logic [W-1:0] y_q;
   logic [N-1:0] onehot_q;
   logic         any_q, multi_q, valid_q;

   logic [W-1:0] winIdx;
   logic [N-1:0] winOh;
   logic         winFound;
   logic         multiNext;
   logic         accept;

   if (MODE == ENC_RR) begin : gRr
      logic [N-1:0] maskVec;
      logic [W-1:0] maskedIdx, fullIdx;
      logic [N-1:0] maskedOh, fullOh;
      logic         maskedFound, fullFound;

      always_comb begin
         maskVec = '0;
         for (int i = 0; i < N; i++) begin
            maskVec[i] = (i >= int'(ptr_q));
         end
      end

      prio_find_first #(.N(N), .DIR(0)) uMasked (
         .vec_i   (d & maskVec),
         .idx_o   (maskedIdx),
         .onehot_o(maskedOh),
         .found_o (maskedFound)
      );

      prio_find_first #(.N(N), .DIR(0)) uFull (
         .vec_i   (d),
         .idx_o   (fullIdx),
         .onehot_o(fullOh),
         .found_o (fullFound)
      );

      // Nothing at or above the pointer means the scan wraps to index 0.
      assign winIdx   = maskedFound ? maskedIdx : fullIdx;
      assign winOh    = maskedFound ? maskedOh  : fullOh;
      assign winFound = fullFound;
   end else begin : gFixed
      prio_find_first #(.N(N), .DIR((MODE == ENC_HIGH_FIRST) ? 1 : 0)) uFind (
         .vec_i   (d),
         .idx_o   (winIdx),
         .onehot_o(winOh),
         .found_o (winFound)
      );
   end

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multiNext = |(d & (d - N'(1)));

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      ptr_d = ptr_q;
      if (MODE == ENC_RR && accept && winFound) begin
         ptr_d = (winIdx == W'(N - 1)) ? '0 : winIdx + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         y_q      <= '0;
         onehot_q <= '0;
         any_q    <= 1'b0;
         multi_q  <= 1'b0;
         ptr_q    <= '0;
      end else begin
         if (accept) begin
            valid_q  <= 1'b1;
            y_q      <= winIdx;
            onehot_q <= winOh;
            any_q    <= winFound;
            multi_q  <= multiNext;
         end else if (out_ready) begin
            valid_q  <= 1'b0;
         end
         ptr_q <= ptr_d;
      end
   end

   assign y         = y_q;
   assign onehot    = onehot_q;
   assign any       = any_q;
   assign multi     = multi_q;
   assign out_valid = valid_q;

endmodule
